// File: rtl/clint_trap_ctrl_if.sv
// ============================================================================
// Module      : clint_trap_ctrl_if
// Description : EX-stage event, CSR access and PC redirect signals between the
//               pipeline and the core-local trap sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clint_trap_ctrl_if;
    logic        inst_ecall_i;
    logic        inst_ebreak_i;
    logic        inst_mret_i;
    logic [31:0] inst_addr_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        irq_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;
    logic        hold_flag_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    // Pipeline / CSR-file side
    modport master (
        output inst_ecall_i, inst_ebreak_i, inst_mret_i, inst_addr_i,
        output br_taken_i, br_target_i, irq_i,
        output csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        input  hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        input  int_assert_o, int_addr_o
    );

    // Trap sequencer side
    modport slave (
        input  inst_ecall_i, inst_ebreak_i, inst_mret_i, inst_addr_i,
        input  br_taken_i, br_target_i, irq_i,
        input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        output hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        output int_assert_o, int_addr_o
    );
endinterface

`default_nettype wire

// File: rtl/clint_trap_ctrl.sv
// ============================================================================
// Module      : clint_trap_ctrl
// Description : Core-local trap sequencer. Holds the pipeline while it writes
//               mepc/mstatus/mcause, then redirects the PC to mtvec or mepc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_trap_ctrl #(
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
    input  wire logic         clk,
    input  wire logic         rst,
    clint_trap_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_W_MEPC    = 3'd1;
    localparam logic [2:0] S_W_MSTATUS = 3'd2;
    localparam logic [2:0] S_W_MCAUSE  = 3'd3;
    localparam logic [2:0] S_ASSERT    = 3'd4;
    localparam logic [2:0] S_MRET      = 3'd5;

    localparam logic [31:0] c_CAUSE_ECALL  = 32'h0000_000B;
    localparam logic [31:0] c_CAUSE_EBREAK = 32'h0000_0003;
    localparam logic [31:0] c_CAUSE_IRQ    = 32'h8000_000B;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_cause;
    logic [31:0] r_epc;      // trap PC, or mepc when returning via mret
    logic [31:0] r_mstatus;
    logic [31:0] r_mtvec;

    logic w_sync;
    logic w_mret;
    logic w_irq;
    logic w_event;

    logic        w_hold;
    logic        w_we;
    logic [11:0] w_waddr;
    logic [31:0] w_wdata;
    logic        w_assert;
    logic [31:0] w_addr;

    // Events are only looked at in IDLE; reset masks them so hold stays low.
    assign w_sync  = bus.inst_ecall_i | bus.inst_ebreak_i;
    assign w_mret  = bus.inst_mret_i;
    assign w_irq   = bus.irq_i & bus.csr_mstatus_i[3];
    assign w_event = ~rst & (r_state == S_IDLE) & (w_sync | w_mret | w_irq);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cause   <= '0;
            r_epc     <= '0;
            r_mstatus <= '0;
            r_mtvec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                if (w_sync) begin
                    r_cause   <= bus.inst_ecall_i ? c_CAUSE_ECALL : c_CAUSE_EBREAK;
                    r_epc     <= bus.inst_addr_i;
                    r_mstatus <= bus.csr_mstatus_i;
                    r_mtvec   <= bus.csr_mtvec_i;
                end else if (w_mret) begin
                    r_epc     <= bus.csr_mepc_i;
                    r_mstatus <= bus.csr_mstatus_i;
                end else if (w_irq) begin
                    r_cause   <= c_CAUSE_IRQ;
                    r_epc     <= bus.br_taken_i ? bus.br_target_i : bus.inst_addr_i;
                    r_mstatus <= bus.csr_mstatus_i;
                    r_mtvec   <= bus.csr_mtvec_i;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_sync)      w_state_nxt = S_W_MEPC;
                else if (w_mret) w_state_nxt = S_MRET;
                else if (w_irq)  w_state_nxt = S_W_MEPC;
                else             w_state_nxt = S_IDLE;
            end
            S_W_MEPC:    w_state_nxt = S_W_MSTATUS;
            S_W_MSTATUS: w_state_nxt = S_W_MCAUSE;
            S_W_MCAUSE:  w_state_nxt = S_ASSERT;
            S_ASSERT:    w_state_nxt = S_IDLE;
            S_MRET:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_hold   = 1'b0;
        w_we     = 1'b0;
        w_waddr  = '0;
        w_wdata  = '0;
        w_assert = 1'b0;
        w_addr   = '0;
        case (r_state)
            S_IDLE: w_hold = w_event;
            S_W_MEPC: begin
                w_hold  = 1'b1;
                w_we    = 1'b1;
                w_waddr = MEPC_ADDR;
                w_wdata = r_epc;
            end
            S_W_MSTATUS: begin
                // MPIE <= MIE, MIE <= 0
                w_hold  = 1'b1;
                w_we    = 1'b1;
                w_waddr = MSTATUS_ADDR;
                w_wdata = {r_mstatus[31:8], r_mstatus[3], r_mstatus[6:4],
                           1'b0, r_mstatus[2:0]};
            end
            S_W_MCAUSE: begin
                w_hold  = 1'b1;
                w_we    = 1'b1;
                w_waddr = MCAUSE_ADDR;
                w_wdata = r_cause;
            end
            S_ASSERT: begin
                w_hold   = 1'b1;
                w_assert = 1'b1;
                w_addr   = r_mtvec;
            end
            S_MRET: begin
                // MIE <= MPIE, MPIE <= 1
                w_hold   = 1'b1;
                w_we     = 1'b1;
                w_waddr  = MSTATUS_ADDR;
                w_wdata  = {r_mstatus[31:8], 1'b1, r_mstatus[6:4],
                            r_mstatus[7], r_mstatus[2:0]};
                w_assert = 1'b1;
                w_addr   = r_epc;
            end
            default: w_hold = 1'b0;
        endcase
    end

    assign bus.hold_flag_o  = w_hold;
    assign bus.csr_we_o     = w_we;
    assign bus.csr_waddr_o  = w_waddr;
    assign bus.csr_wdata_o  = w_wdata;
    assign bus.int_assert_o = w_assert;
    assign bus.int_addr_o   = w_addr;

endmodule

`default_nettype wire

// File: tb/tb_clint_trap_ctrl.sv
// ============================================================================
// Module      : tb_clint_trap_ctrl
// Description : Directed, table-driven self-checking bench for clint_trap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clint_trap_ctrl;

    typedef struct packed {
        logic        ecall;
        logic        ebreak;
        logic        mret;
        logic        irq;
        logic        br;
        logic [31:0] addr;
        logic [31:0] tgt;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] mstatus;
        logic        e_hold;
        logic        e_we;
        logic [11:0] e_waddr;
        logic [31:0] e_wdata;
        logic        e_as;
        logic [31:0] e_iaddr;
    } vec_t;

    localparam int c_NVEC = 24;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t tbl [c_NVEC];

    clint_trap_ctrl_if bus ();

    clint_trap_ctrl #(
        .MSTATUS_ADDR (12'h300),
        .MEPC_ADDR    (12'h341),
        .MCAUSE_ADDR  (12'h342)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ec, input logic eb, input logic mr,
                                input logic iq, input logic br,
                                input logic [31:0] addr, input logic [31:0] tgt,
                                input logic [31:0] mtvec, input logic [31:0] mepc,
                                input logic [31:0] mst, input logic h,
                                input logic we, input logic [11:0] wa,
                                input logic [31:0] wd, input logic as_,
                                input logic [31:0] ia);
        vec_t v;
        v.ecall = ec;  v.ebreak = eb; v.mret = mr; v.irq = iq; v.br = br;
        v.addr = addr; v.tgt = tgt; v.mtvec = mtvec; v.mepc = mepc;
        v.mstatus = mst; v.e_hold = h; v.e_we = we; v.e_waddr = wa;
        v.e_wdata = wd; v.e_as = as_; v.e_iaddr = ia;
        return v;
    endfunction

    task automatic drive(input logic ec, input logic eb, input logic mr,
                         input logic iq, input logic br,
                         input logic [31:0] addr, input logic [31:0] tgt,
                         input logic [31:0] mtvec, input logic [31:0] mepc,
                         input logic [31:0] mst);
        bus.inst_ecall_i  = ec;
        bus.inst_ebreak_i = eb;
        bus.inst_mret_i   = mr;
        bus.irq_i         = iq;
        bus.br_taken_i    = br;
        bus.inst_addr_i   = addr;
        bus.br_target_i   = tgt;
        bus.csr_mtvec_i   = mtvec;
        bus.csr_mepc_i    = mepc;
        bus.csr_mstatus_i = mst;
    endtask

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Compares all six outputs at the current (mid-cycle) sample point.
    task automatic chk(input string name, input logic h, input logic we,
                       input logic [11:0] wa, input logic [31:0] wd,
                       input logic as_, input logic [31:0] ia);
        cmp({name, ".hold"},   {31'd0, bus.hold_flag_o},  {31'd0, h});
        cmp({name, ".we"},     {31'd0, bus.csr_we_o},     {31'd0, we});
        cmp({name, ".waddr"},  {20'd0, bus.csr_waddr_o},  {20'd0, wa});
        cmp({name, ".wdata"},  bus.csr_wdata_o,           wd);
        cmp({name, ".assert"}, {31'd0, bus.int_assert_o}, {31'd0, as_});
        cmp({name, ".iaddr"},  bus.int_addr_o,            ia);
    endtask

    // Inputs change just after posedge, outputs sampled at negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // ecall @0x100, mtvec 0x200, MIE set
        tbl[0]  = mk(0,0,0,0,0, 32'h0,   32'h0,   32'h200, 32'h0,   32'h8,    0,0,12'h0,  32'h0,        0,32'h0);
        tbl[1]  = mk(1,0,0,0,0, 32'h100, 32'h0,   32'h200, 32'h0,   32'h8,    1,0,12'h0,  32'h0,        0,32'h0);
        tbl[2]  = mk(1,0,0,0,0, 32'h100, 32'h0,   32'h200, 32'h0,   32'h8,    1,1,12'h341,32'h100,      0,32'h0);
        tbl[3]  = mk(1,0,0,0,0, 32'h100, 32'h0,   32'h200, 32'h0,   32'h8,    1,1,12'h300,32'h80,       0,32'h0);
        tbl[4]  = mk(1,0,0,0,0, 32'h100, 32'h0,   32'h200, 32'h0,   32'h8,    1,1,12'h342,32'hB,        0,32'h0);
        tbl[5]  = mk(1,0,0,0,0, 32'h100, 32'h0,   32'h200, 32'h0,   32'h8,    1,0,12'h0,  32'h0,        1,32'h200);
        tbl[6]  = mk(0,0,0,0,0, 32'h104, 32'h0,   32'h200, 32'h0,   32'h8,    0,0,12'h0,  32'h0,        0,32'h0);
        // irq while a branch is taken: epc is the branch target
        tbl[7]  = mk(0,0,0,1,1, 32'h120, 32'h340, 32'h200, 32'h0,   32'h8,    1,0,12'h0,  32'h0,        0,32'h0);
        tbl[8]  = mk(0,0,0,1,1, 32'h120, 32'h340, 32'h200, 32'h0,   32'h8,    1,1,12'h341,32'h340,      0,32'h0);
        tbl[9]  = mk(0,0,0,1,1, 32'h120, 32'h340, 32'h200, 32'h0,   32'h8,    1,1,12'h300,32'h80,       0,32'h0);
        tbl[10] = mk(0,0,0,1,1, 32'h120, 32'h340, 32'h200, 32'h0,   32'h8,    1,1,12'h342,32'h8000000B, 0,32'h0);
        tbl[11] = mk(0,0,0,0,0, 32'h120, 32'h340, 32'h200, 32'h0,   32'h8,    1,0,12'h0,  32'h0,        1,32'h200);
        tbl[12] = mk(0,0,0,0,0, 32'h124, 32'h0,   32'h200, 32'h0,   32'h80,   0,0,12'h0,  32'h0,        0,32'h0);
        // mret: mstatus 0x80 -> 0x88, redirect to mepc
        tbl[13] = mk(0,0,1,0,0, 32'h128, 32'h0,   32'h200, 32'h104, 32'h80,   1,0,12'h0,  32'h0,        0,32'h0);
        tbl[14] = mk(0,0,1,0,0, 32'h128, 32'h0,   32'h200, 32'h104, 32'h80,   1,1,12'h300,32'h88,       1,32'h104);
        tbl[15] = mk(0,0,0,0,0, 32'h104, 32'h0,   32'h200, 32'h0,   32'h88,   0,0,12'h0,  32'h0,        0,32'h0);
        // ebreak, upper mstatus bits preserved
        tbl[16] = mk(0,1,0,0,0, 32'h200, 32'h0,   32'h400, 32'h0,   32'h1808, 1,0,12'h0,  32'h0,        0,32'h0);
        tbl[17] = mk(0,1,0,0,0, 32'h200, 32'h0,   32'h400, 32'h0,   32'h1808, 1,1,12'h341,32'h200,      0,32'h0);
        tbl[18] = mk(0,1,0,0,0, 32'h200, 32'h0,   32'h400, 32'h0,   32'h1808, 1,1,12'h300,32'h1880,     0,32'h0);
        tbl[19] = mk(0,1,0,0,0, 32'h200, 32'h0,   32'h400, 32'h0,   32'h1808, 1,1,12'h342,32'h3,        0,32'h0);
        // mret presented during ASSERT is ignored, then taken with no idle gap
        tbl[20] = mk(0,0,1,0,0, 32'h200, 32'h0,   32'h400, 32'h208, 32'h1880, 1,0,12'h0,  32'h0,        1,32'h400);
        tbl[21] = mk(0,0,1,0,0, 32'h400, 32'h0,   32'h400, 32'h208, 32'h1880, 1,0,12'h0,  32'h0,        0,32'h0);
        tbl[22] = mk(0,0,1,0,0, 32'h400, 32'h0,   32'h400, 32'h208, 32'h1880, 1,1,12'h300,32'h1888,     1,32'h208);
        tbl[23] = mk(0,0,0,0,0, 32'h208, 32'h0,   32'h400, 32'h0,   32'h1888, 0,0,12'h0,  32'h0,        0,32'h0);

        rst = 1'b1;
        drive(1,0,0,1,0, 32'h100, 32'h0, 32'h200, 32'h0, 32'h8);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset", 0,0,12'h0,32'h0,0,32'h0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < c_NVEC; i++) begin
            drive(tbl[i].ecall, tbl[i].ebreak, tbl[i].mret, tbl[i].irq, tbl[i].br,
                  tbl[i].addr, tbl[i].tgt, tbl[i].mtvec, tbl[i].mepc, tbl[i].mstatus);
            @(negedge clk);
            chk($sformatf("vec%0d", i), tbl[i].e_hold, tbl[i].e_we, tbl[i].e_waddr,
                tbl[i].e_wdata, tbl[i].e_as, tbl[i].e_iaddr);
            next_cycle();
        end

        // irq masked by MIE=0 for 10 cycles, then taken once MIE is set
        drive(0,0,0,1,0, 32'h500, 32'h0, 32'h600, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("masked%0d", i), 0,0,12'h0,32'h0,0,32'h0);
            next_cycle();
        end
        bus.csr_mstatus_i = 32'h8;
        @(negedge clk); chk("unmask.detect", 1,0,12'h0,32'h0,0,32'h0);
        next_cycle();
        @(negedge clk); chk("unmask.mepc", 1,1,12'h341,32'h500,0,32'h0);
        next_cycle();
        @(negedge clk); chk("unmask.mstatus", 1,1,12'h300,32'h80,0,32'h0);
        next_cycle();
        @(negedge clk); chk("unmask.mcause", 1,1,12'h342,32'h8000000B,0,32'h0);
        next_cycle();
        bus.irq_i = 1'b0;
        @(negedge clk); chk("unmask.assert", 1,0,12'h0,32'h0,1,32'h600);
        next_cycle();

        // ecall + irq together: sync wins; irq then stays masked until mret
        drive(1,0,0,1,0, 32'h300, 32'h0, 32'h200, 32'h0, 32'h8);
        @(negedge clk); chk("both.detect", 1,0,12'h0,32'h0,0,32'h0);
        next_cycle();
        @(negedge clk); chk("both.mepc", 1,1,12'h341,32'h300,0,32'h0);
        next_cycle();
        @(negedge clk); chk("both.mstatus", 1,1,12'h300,32'h80,0,32'h0);
        next_cycle();
        @(negedge clk); chk("both.mcause", 1,1,12'h342,32'hB,0,32'h0);
        next_cycle();
        @(negedge clk); chk("both.assert", 1,0,12'h0,32'h0,1,32'h200);
        next_cycle();
        drive(0,0,0,1,0, 32'h200, 32'h0, 32'h200, 32'h304, 32'h80);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("nore%0d", i), 0,0,12'h0,32'h0,0,32'h0);
            next_cycle();
        end
        bus.inst_mret_i = 1'b1;
        @(negedge clk); chk("mret2.detect", 1,0,12'h0,32'h0,0,32'h0);
        next_cycle();
        @(negedge clk); chk("mret2.exec", 1,1,12'h300,32'h88,1,32'h304);
        next_cycle();
        drive(0,0,0,1,0, 32'h304, 32'h0, 32'h200, 32'h0, 32'h88);
        @(negedge clk); chk("retake.detect", 1,0,12'h0,32'h0,0,32'h0);
        next_cycle();
        @(negedge clk); chk("retake.mepc", 1,1,12'h341,32'h304,0,32'h0);
        next_cycle();
        @(negedge clk); chk("retake.mstatus", 1,1,12'h300,32'h1008 & 32'h80 | 32'h80,0,32'h0);
        next_cycle();
        @(negedge clk); chk("retake.mcause", 1,1,12'h342,32'h8000000B,0,32'h0);
        next_cycle();
        bus.irq_i = 1'b0;
        @(negedge clk); chk("retake.assert", 1,0,12'h0,32'h0,1,32'h200);
        next_cycle();

        // reset while in W_MSTATUS aborts the sequence
        drive(1,0,0,0,0, 32'h700, 32'h0, 32'h800, 32'h0, 32'h8);
        @(negedge clk); chk("rst.detect", 1,0,12'h0,32'h0,0,32'h0);
        next_cycle();
        @(negedge clk); chk("rst.mepc", 1,1,12'h341,32'h700,0,32'h0);
        next_cycle();
        @(negedge clk); chk("rst.mstatus", 1,1,12'h300,32'h80,0,32'h0);
        rst = 1'b1;
        bus.inst_ecall_i = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst.after%0d", i), 0,0,12'h0,32'h0,0,32'h0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/clint_trap_ctrl.md
Name: clint_trap_ctrl

Overview:
- Core-local interrupt/trap sequencer; the initiator of the pipeline hold request that the hold-distribution controller fans out to all five stages.
- Detects ecall/ebreak/mret in the EX stage and level external interrupts.
- Stalls the pipeline while it writes mepc, mstatus and mcause through the CSR write port.
- Then redirects the PC to mtvec on a trap, or to mepc on mret.

Parameters:
- MSTATUS_ADDR, 12'h300, CSR address of mstatus
- MEPC_ADDR, 12'h341, CSR address of mepc
- MCAUSE_ADDR, 12'h342, CSR address of mcause

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- inst_ecall_i  in  1  EX-stage instruction is ecall
- inst_ebreak_i  in  1  EX-stage instruction is ebreak
- inst_mret_i  in  1  EX-stage instruction is mret
- inst_addr_i  in  32  PC of EX-stage instruction
- br_taken_i  in  1  EX-stage branch/jump taken this cycle
- br_target_i  in  32  EX-stage branch/jump target
- irq_i  in  1  external interrupt request, level-sensitive
- csr_mtvec_i  in  32  current mtvec
- csr_mepc_i  in  32  current mepc
- csr_mstatus_i  in  32  current mstatus
- hold_flag_o  out  1  pipeline hold request to controller
- csr_we_o  out  1  CSR write enable
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  32  CSR write data
- int_assert_o  out  1  PC redirect strobe, one cycle
- int_addr_o  out  32  PC redirect target, valid when int_assert_o=1

Behaviour:
- Reset, also when applied mid-sequence:
  - state=IDLE; all latched registers=0.
  - hold_flag_o=0, csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, int_assert_o=0, int_addr_o=0.
  - No partial CSR writes complete after reset.
- States: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, ASSERT, MRET.
- Event detection happens only in IDLE. Priority, highest first:
  1. sync trap (ecall or ebreak)
  2. mret
  3. async irq, taken only when irq_i=1 and csr_mstatus_i[3] (MIE)=1
- Sync trap detected in IDLE (cycle 0):
  - Latch cause: ecall=32'h0000000B, ebreak=32'h00000003 (ecall wins if both).
  - Latch epc=inst_addr_i, mstatus=csr_mstatus_i, mtvec=csr_mtvec_i.
  - Next state W_MEPC.
- Async irq detected in IDLE (cycle 0):
  - Latch cause=32'h8000000B.
  - Latch epc=br_taken_i ? br_target_i : inst_addr_i; also latch mstatus and mtvec.
  - Next state W_MEPC.
- Trap sequence, one cycle per state:
  - W_MEPC: we=1, addr=MEPC_ADDR, data=epc.
  - W_MSTATUS: we=1, addr=MSTATUS_ADDR, data=latched mstatus with bit7 (MPIE)=old bit3 and bit3 (MIE)=0; other bits unchanged.
  - W_MCAUSE: we=1, addr=MCAUSE_ADDR, data=cause.
  - ASSERT: int_assert_o=1, int_addr_o=latched mtvec, we=0; next state IDLE.
- mret detected in IDLE:
  - Latch mstatus=csr_mstatus_i and mepc=csr_mepc_i; next state MRET.
  - MRET cycle: we=1, addr=MSTATUS_ADDR, data with bit3=old bit7 and bit7=1.
  - Same cycle: int_assert_o=1, int_addr_o=latched mepc; next state IDLE.
- hold_flag_o (combinational) = (state==IDLE && an event is detected) || state!=IDLE.
  - Trap: hold high for 5 consecutive cycles (detect..ASSERT).
  - mret: hold high for 2 consecutive cycles.
- All other cycles: csr_we_o=0 and int_assert_o=0. csr_waddr_o, csr_wdata_o and int_addr_o are driven 0 when their strobe is low.
- Events arriving while state!=IDLE are ignored, not queued. The EX instruction is frozen by the hold. irq_i is re-sampled on return to IDLE.
- Since MIE=0 after a trap, a still-asserted irq_i is not retaken until an mret restores MIE.
- Simultaneous events:
  - sync trap + irq: sync taken; irq evaluated again afterwards.
  - mret + irq: mret taken.
- Back-to-back: the first IDLE cycle after ASSERT or MRET may detect a new event. There is no mandatory idle gap.

Test Plan:
- ecall at inst_addr_i=0x100, mtvec=0x200, mstatus=0x8:
  - hold high for 5 cycles.
  - CSR writes in order: 0x341←0x100, 0x300←0x80, 0x342←0xB.
  - Then int_assert_o=1 with int_addr_o=0x200.
- irq_i=1, mstatus=0x8, br_taken_i=1, br_target_i=0x340: mepc←0x340, mcause←0x8000000B, redirect to mtvec.
- irq_i=1 with mstatus=0x0: no hold, no writes for 10 cycles. Then set mstatus=0x8 → trap taken the next cycle.
- mret with mepc=0x104, mstatus=0x80: hold high for 2 cycles; 0x300←0x88 and int_addr_o=0x104 in the same cycle.
- ecall and irq_i together: mcause←0xB. irq held high afterwards is not retaken until an mret sets mstatus back to 0x88.
- rst asserted during W_MSTATUS: the next cycle has all outputs 0 and state IDLE. No mcause write and no int_assert_o.
